// File: rtl/kb_cmd_decoder.sv
// kb_cmd_decoder: turns PS/2 scan bytes into flap/restart/pause game commands
module kb_cmd_decoder #(
    parameter int FLAP_GAP       = 2500000,
    parameter int PREFIX_TIMEOUT = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] keycode,
    input  logic       sign,
    output logic       flap,
    output logic       restart,
    output logic       pause,
    output logic       space_held,
    output logic [7:0] last_code
);
    localparam int GW = (FLAP_GAP > 1) ? $clog2(FLAP_GAP) : 1;
    localparam int PW = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(FLAP_GAP - 1);
    localparam logic [PW-1:0] PFX_LOAD = PW'(PREFIX_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t        state;
    logic [GW-1:0] gap_cnt;
    logic [PW-1:0] pfx_cnt;
    logic          is_e0, is_f0, is_final, ext, brk, flap_key, fire;

    // classify the incoming byte against the pending prefix state
    always_comb begin
        is_e0    = keycode == 8'hE0;
        is_f0    = keycode == 8'hF0;
        is_final = keycode != 8'h00 && !is_e0 && !is_f0;
        ext      = state == EXT || state == EXT_BRK;
        brk      = state == BRK || state == EXT_BRK || !sign;
        flap_key = ext ? keycode == 8'h75 : keycode == 8'h29;
        fire     = is_final && flap_key && !brk && !space_held && !pause && gap_cnt == '0;
    end

    // prefix FSM, timers and registered command outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            gap_cnt    <= '0;
            pfx_cnt    <= '0;
            flap       <= 1'b0;
            restart    <= 1'b0;
            pause      <= 1'b0;
            space_held <= 1'b0;
            last_code  <= 8'h00;
        end else begin
            flap    <= 1'b0;
            restart <= 1'b0;
            if (gap_cnt != '0)
                gap_cnt <= gap_cnt - 1'b1;
            if (state != IDLE && pfx_cnt != '0)
                pfx_cnt <= pfx_cnt - 1'b1;
            if (is_e0) begin
                state   <= (state == BRK) ? EXT_BRK : EXT;
                pfx_cnt <= PFX_LOAD;
            end else if (is_f0) begin
                state   <= ext ? EXT_BRK : BRK;
                pfx_cnt <= PFX_LOAD;
            end else if (is_final) begin
                state     <= IDLE;
                last_code <= keycode;
                if (flap_key)
                    space_held <= !brk;
                else if (!brk && !ext && keycode == 8'h4D)
                    pause <= !pause;
                else if (!brk && keycode == 8'h5A) begin
                    restart <= 1'b1;
                    pause   <= 1'b0;
                end
                if (fire) begin
                    flap    <= 1'b1;
                    gap_cnt <= GAP_LOAD;
                end
            end else if (state != IDLE && pfx_cnt == '0)
                state <= IDLE;
        end
    end
endmodule

// File: tb/tb_kb_cmd_decoder.sv
// tb_kb_cmd_decoder: randomized and directed checks against a cycle-count reference model
module tb_kb_cmd_decoder;
    localparam int FG = 10;
    localparam int PT = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic       sign = 1'b1;
    logic       flap, restart, pause, space_held;
    logic [7:0] last_code;

    kb_cmd_decoder #(.FLAP_GAP(FG), .PREFIX_TIMEOUT(PT)) dut (
        .clk(clk), .rst_n(rst_n), .keycode(keycode), .sign(sign),
        .flap(flap), .restart(restart), .pause(pause),
        .space_held(space_held), .last_code(last_code)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int flap_cnt = 0;
    int rst_cnt = 0;

    // reference model: prefix remembered as flags plus the cycle it arrived,
    // flap spacing measured from the cycle of the last accepted flap
    int   cyc = 0;
    bit   pend, m_ext, m_brk;
    int   pcyc;
    bit   flapped;
    int   lfc;
    logic e_flap, e_restart, e_pause, e_held;
    logic [7:0] e_last;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pend = 0; m_ext = 0; m_brk = 0; flapped = 0;
        e_flap = 0; e_restart = 0; e_pause = 0; e_held = 0; e_last = 8'h00;
    endtask

    task automatic model_step(input logic [7:0] k, input logic s);
        bit valid, x, b, fk;
        cyc++;
        e_flap = 0;
        e_restart = 0;
        valid = pend && (cyc - pcyc <= PT);
        if (k == 8'h00) begin
            if (pend && cyc - pcyc >= PT) pend = 0;
        end else if (k == 8'hE0) begin
            m_brk = valid && m_brk && !m_ext;
            m_ext = 1; pend = 1; pcyc = cyc;
        end else if (k == 8'hF0) begin
            m_ext = valid && m_ext;
            m_brk = 1; pend = 1; pcyc = cyc;
        end else begin
            x = valid && m_ext;
            b = (valid && m_brk) || !s;
            pend = 0;
            e_last = k;
            fk = x ? (k == 8'h75) : (k == 8'h29);
            if (fk) begin
                if (!b && !e_held && !e_pause && (!flapped || cyc - lfc >= FG)) begin
                    e_flap = 1; flapped = 1; lfc = cyc;
                end
                e_held = !b;
            end else if (!b && !x && k == 8'h4D)
                e_pause = !e_pause;
            else if (!b && k == 8'h5A) begin
                e_restart = 1; e_pause = 0;
            end
        end
    endtask

    // compare process: DUT against model on every falling edge out of reset
    always @(negedge clk) begin
        if (rst_n) begin
            chk("flap", flap, e_flap);
            chk("restart", restart, e_restart);
            chk("pause", pause, e_pause);
            chk("space_held", space_held, e_held);
            chk("last_code", last_code, e_last);
            flap_cnt += int'(flap);
            rst_cnt += int'(restart);
        end
    end

    task automatic send(input logic [7:0] k, input logic s = 1'b1);
        keycode = k;
        sign = s;
        @(posedge clk);
        model_step(k, s);
        #1 keycode = 8'h00;
        sign = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(8'h00);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("async_flap", flap, 0);
        chk("async_held", space_held, 0);
        chk("async_pause", pause, 0);
        chk("async_last", last_code, 0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        flap_cnt = 0;
        rst_cnt = 0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_last", last_code, 8'h00);
        chk("reset_pause", pause, 0);
        #1;
        idle(2);

        // space make, break, single pulse
        send(8'h29); send(8'hF0); send(8'h29, 1'b0); idle(2);
        chk("d038_flaps", flap_cnt, 1);
        chk("d038_held", space_held, 0);
        chk("d038_last", last_code, 8'h29);

        // typematic repeat
        do_reset(); idle(1);
        send(8'h29); send(8'h29); send(8'h29); idle(2);
        chk("d039_flaps", flap_cnt, 1);
        chk("d039_held", space_held, 1);

        // gap suppression then allowed second flap
        do_reset(); idle(1);
        send(8'h29); send(8'hF0); send(8'h29); idle(2);
        send(8'h29); send(8'hF0); send(8'h29); idle(4);
        chk("d040_suppressed", flap_cnt, 1);
        send(8'h29); idle(2);
        chk("d040_second", flap_cnt, 2);

        // pause blocks flap, enter restarts and unpauses
        do_reset(); idle(1);
        send(8'h4D); send(8'hF0); send(8'h4D); idle(1);
        chk("d041_pause", pause, 1);
        send(8'h29); idle(1);
        chk("d041_noflap", flap_cnt, 0);
        send(8'h5A); send(8'hF0); send(8'h5A); idle(1);
        chk("d041_restart", rst_cnt, 1);
        chk("d041_unpause", pause, 0);

        // stale E0 prefix times out
        do_reset(); idle(1);
        send(8'hE0); idle(10); send(8'h75); idle(1);
        chk("d042_noflap", flap_cnt, 0);
        chk("d042_last", last_code, 8'h75);

        // extended up arrow within timeout flaps
        send(8'hE0); idle(3); send(8'h75); idle(1);
        chk("ext_up_flap", flap_cnt, 1);

        // reset mid-prefix
        send(8'h29, 1'b0); send(8'hF0);
        do_reset(); idle(1);
        send(8'h29); idle(1);
        chk("d043_flap", flap_cnt, 1);

        // randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic [7:0] k;
            r = $urandom_range(0, 99);
            k = r < 45 ? 8'h00 : r < 55 ? 8'hE0 : r < 65 ? 8'hF0 : r < 75 ? 8'h29 :
                r < 83 ? 8'h75 : r < 88 ? 8'h4D : r < 92 ? 8'h5A : 8'($urandom_range(1, 255));
            send(k, logic'($urandom_range(0, 9) != 0));
            if (r == 0) idle($urandom_range(5, 15));
        end
        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/kb_cmd_decoder.md
KB_CMD_DECODER -- requirements
Module: kb_cmd_decoder

Interface
REQ-001 Parameter FLAP_GAP, default 2500000, minimum clk cycles between two flap pulses (25 ms at 100 MHz).
REQ-002 Parameter PREFIX_TIMEOUT, default 1000000, clk cycles a pending E0/F0 prefix survives without a following byte.
REQ-003 clk  input  1  system clock, all logic on posedge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 keycode  input  8  scan byte from the PS/2 receiver; valid for exactly the cycle it is nonzero, 8'h00 = no byte.
REQ-006 sign  input  1  receiver break hint, sampled only when keycode != 0; 0 = byte followed an F0.
REQ-007 flap  output  1  one-cycle pulse, bird flap command.
REQ-008 restart  output  1  one-cycle pulse, game restart command.
REQ-009 pause  output  1  level, 1 = game paused.
REQ-010 space_held  output  1  level, 1 = space or up-arrow currently held.
REQ-011 last_code  output  8  last non-prefix scan code accepted.

Function
REQ-012 Byte event = cycle with keycode != 0; all other cycles are idle, and only the timers advance.
REQ-013 Prefix FSM states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0).
REQ-014 Transitions: E0 in IDLE/EXT/EXT_BRK -> EXT; E0 in BRK -> EXT_BRK; F0 in IDLE/BRK -> BRK; F0 in EXT/EXT_BRK -> EXT_BRK.
REQ-015 Any other byte is a final code, decoded in the same cycle; the FSM returns to IDLE on the next cycle.
REQ-016 A final code is a break if the state is BRK/EXT_BRK or sign == 0, otherwise a make.
REQ-017 A final code is extended if the state is EXT/EXT_BRK.
REQ-018 Flap keys: 29 non-extended (space) and 75 extended (up arrow); extended 29 and non-extended 75 are not flap keys.
REQ-019 Flap-key make with space_held == 0, pause == 0 and the gap counter at 0: flap = 1 the next cycle, gap counter loads FLAP_GAP-1.
REQ-020 Flap-key make always sets space_held, even if the flap is suppressed.
REQ-021 Flap-key break clears space_held and produces no pulse.
REQ-022 Flap-key make with space_held == 1 (typematic repeat) produces no pulse.
REQ-023 Gap counter decrements by 1 per cycle while nonzero and saturates at 0.
REQ-024 Gap counter width is clog2(FLAP_GAP).
REQ-025 A flap request arriving while the gap counter is nonzero is dropped, not queued.
REQ-026 4D (P) make, non-extended: pause toggles on the next cycle; 4D break has no effect.
REQ-027 5A (Enter) make, non-extended: restart = 1 the next cycle and pause clears on the same edge; pause clears even if set.
REQ-028 Extended 5A (keypad Enter) acts like 5A.
REQ-029 last_code updates to the final code on every final code, make or break, known or unknown.
REQ-030 Unknown final codes return the FSM to IDLE and change no other output.
REQ-031 Prefix timer reloads PREFIX_TIMEOUT-1 on every prefix byte and decrements while the FSM is not IDLE.
REQ-032 When the prefix timer reaches 0 with the FSM not IDLE, the FSM returns to IDLE and the pending prefix is discarded.
REQ-033 A byte arriving on the same cycle the prefix timer expires is processed against the pre-expiry state.
REQ-034 flap and restart are never high for more than one consecutive cycle, and never high together.

Reset
REQ-035 rst_n low immediately forces: FSM = IDLE; flap, restart, pause, space_held = 0; last_code = 8'h00; both timers = 0.
REQ-036 Reset mid-prefix discards the prefix; the first byte after release is decoded from IDLE.
REQ-037 Outputs hold their reset values until the first posedge clk after rst_n rises.

Verification
REQ-038 Bytes 29 (sign=1), F0, 29 (sign=0): flap pulses once for 1 cycle, space_held goes 1 then 0, last_code = 29.
REQ-039 Bytes 29, 29, 29 with no break: exactly one flap pulse, and space_held stays 1.
REQ-040 FLAP_GAP = 10; make/break space, then make again 5 cycles after the first flap: no second pulse. Repeat at 12 cycles: second pulse.
REQ-041 Bytes 4D, F0, 4D: pause = 1; then byte 29: no flap; then bytes 5A, F0, 5A: restart pulses once and pause = 0.
REQ-042 PREFIX_TIMEOUT = 8; byte E0, idle 10 cycles, then byte 75: treated as non-extended, no flap, last_code = 75.
REQ-043 rst_n pulsed low after byte F0: outputs cleared asynchronously; next byte 29 (sign=1) after release gives flap = 1.
